instruction_fetch: RTL and testbench

Fetch stage of the single-cycle processor. Holds the program counter and fetches one instruction per step from instruction memory over a req/ack handshake. Presents the instruction, held stable, to the control-flag decoder and datapath. Computes the next PC from the decoder's `branch_select` and `jump_select` and the ALU zero result. Supports a downstream stall and counts retired instructions.

---
 rtl/instruction_fetch.sv | 101 ++++++++++
 tb/tb_instruction_fetch.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, fetches one instruction per step over req/ack, computes next PC.
// Latency: 2 cycles minimum per instruction (FETCH with ack, EXEC); +1 per ack-wait or stall cycle.
// Backpressure: stall holds EXEC (pc, instruction, retired_count frozen); memory delays via imem_ack.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        branch_select,
    input  logic        jump_select,
    input  logic        alu_zero,
    input  logic        stall,
    output logic [31:0] retired_count
);

    typedef enum logic {FETCH, EXEC} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt;
    logic [31:0] instr_r;
    logic [31:0] instr_nxt;
    logic [31:0] count_r;
    logic [31:0] count_nxt;
    logic [31:0] next_pc;
    logic [31:0] branch_off;
    logic [31:0] jump_target;

    assign pc            = pc_r;
    assign pc_plus4      = pc_r + 32'd4;
    assign imem_addr     = pc_r;
    assign instruction   = instr_r;
    assign retired_count = count_r;

    // Branch offset is a word offset; jump keeps the upper nibble of the sequential PC.
    assign branch_off  = {{14{instr_r[15]}}, instr_r[15:0], 2'b00};
    assign jump_target = {pc_plus4[31:28], instr_r[25:0], 2'b00};

    // Next-PC mux: jump wins over a taken branch, otherwise sequential.
    always_comb begin
        next_pc = pc_plus4;
        if (jump_select) begin
            next_pc = jump_target;
        end else if (branch_select && alu_zero) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    // State, PC, instruction and retire counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            pc_r    <= RESET_PC;
            instr_r <= 32'h0;
            count_r <= 32'h0;
        end else begin
            state   <= state_nxt;
            pc_r    <= pc_nxt;
            instr_r <= instr_nxt;
            count_r <= count_nxt;
        end
    end

    // Next-state and handshake decode; req/valid come only from the registered state.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc_r;
        instr_nxt   = instr_r;
        count_nxt   = count_r;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_nxt = imem_rdata;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    pc_nxt    = next_pc;
                    count_nxt = count_r + 32'd1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a retire/fetch scoreboard.
// Driver pushes expected fetch addresses and retire records; a negedge monitor pops and compares.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_instruction_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] cnt;
    } retire_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch_select;
    logic        jump_select;
    logic        alu_zero;
    logic        stall;
    logic [31:0] retired_count;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic        mon_en = 1'b0;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic [31:0] last_instr;

    logic [31:0] fetch_q[$];
    retire_t     retire_q[$];

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .branch_select (branch_select),
        .jump_select   (jump_select),
        .alu_zero      (alu_zero),
        .stall         (stall),
        .retired_count (retired_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted fetch and every retiring instruction is matched to the scoreboard.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (imem_req && imem_ack) begin
                if (fetch_q.size() == 0) begin
                    chk("fetch_unexpected", imem_addr, 32'hxxxx_xxxx);
                end else begin
                    chk("fetch_addr", imem_addr, fetch_q.pop_front());
                end
            end
            if (instr_valid && !stall) begin
                if (retire_q.size() == 0) begin
                    chk("retire_unexpected", pc, 32'hxxxx_xxxx);
                end else begin
                    retire_t r;
                    r = retire_q.pop_front();
                    chk("retire_pc", pc, r.pc);
                    chk("retire_instr", instruction, r.instr);
                    chk("retire_count", retired_count, r.cnt);
                end
            end
        end
    end

    // FETCH-cycle checks, sampled on the falling edge.
    task automatic chk_fetch_cycle();
        @(negedge clk);
        chk("fetch_req", {31'b0, imem_req}, 32'd1);
        chk("fetch_valid", {31'b0, instr_valid}, 32'd0);
        chk("fetch_addr_hold", imem_addr, exp_pc);
        chk("fetch_pc_plus4", pc_plus4, exp_pc + 32'd4);
        chk("fetch_instr_hold", instruction, last_instr);
        chk("fetch_count", retired_count, exp_cnt);
    endtask

    // One instruction step: ack after ack_delay cycles, stall EXEC for stall_cyc cycles.
    // Entered and left 1ns after the rising edge that starts a FETCH cycle.
    task automatic step(input logic [31:0] rdata, input int ack_delay, input int stall_cyc,
                        input logic br, input logic jmp, input logic z, input logic [31:0] exp_next);
        imem_ack = 1'b0;
        stall    = (ack_delay > 0);
        branch_select = 1'b1;
        jump_select   = 1'b1;
        alu_zero      = 1'b1;
        for (int i = 0; i < ack_delay; i++) begin
            imem_rdata = 32'hBAD0_0000 + i;
            chk_fetch_cycle();
            @(posedge clk); #1;
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        fetch_q.push_back(exp_pc);
        retire_q.push_back('{pc: exp_pc, instr: rdata, cnt: exp_cnt});
        chk_fetch_cycle();
        @(posedge clk); #1;
        imem_ack      = 1'b0;
        imem_rdata    = 32'hFFFF_0000;
        branch_select = br;
        jump_select   = jmp;
        alu_zero      = z;
        stall         = (stall_cyc > 0);
        for (int i = 0; i < stall_cyc; i++) begin
            @(negedge clk);
            chk("stall_req", {31'b0, imem_req}, 32'd0);
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall_instr", instruction, rdata);
            chk("stall_pc", pc, exp_pc);
            chk("stall_count", retired_count, exp_cnt);
            @(posedge clk); #1;
        end
        stall = 1'b0;
        @(posedge clk); #1;
        branch_select = 1'b0;
        jump_select   = 1'b0;
        alu_zero      = 1'b0;
        last_instr    = rdata;
        exp_pc        = exp_next;
        exp_cnt       = exp_cnt + 32'd1;
    endtask

    initial begin
        reset = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        branch_select = 1'b0;
        jump_select = 1'b0;
        alu_zero = 1'b0;
        stall = 1'b0;
        exp_pc = 32'h0;
        exp_cnt = 32'h0;
        last_instr = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        //   rdata          delay stall br  jmp z   expected next pc
        step(32'h8C01_0004, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0004);
        step(32'h1000_FFFD, 0, 0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
        step(32'h0800_0002, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0008);
        step(32'h0800_0004, 3, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0010);
        step(32'h1000_FFFE, 0, 0, 1'b1, 1'b0, 1'b1, 32'h0000_000C);
        step(32'h0800_0004, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0010);
        step(32'h1000_FFFE, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0014);
        step(32'h0000_0020, 0, 4, 1'b0, 1'b0, 1'b0, 32'h0000_0018);
        step(32'h0BFF_FFFF, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0FFF_FFFC);
        step(32'h0800_0010, 0, 0, 1'b0, 1'b1, 1'b0, 32'h1000_0040);
        step(32'h0800_0100, 0, 0, 1'b0, 1'b1, 1'b0, 32'h1000_0400);
        step(32'h1000_FF0F, 0, 0, 1'b1, 1'b0, 1'b1, 32'h1000_0040);
        step(32'h0800_0100, 0, 0, 1'b1, 1'b1, 1'b1, 32'h1000_0400);

        // Reset in FETCH with a simultaneous ack: the word must not be captured.
        chk_fetch_cycle();
        @(posedge clk); #1;
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        reset    = 1'b0;
        imem_ack = 1'b0;
        exp_pc     = 32'h0;
        exp_cnt    = 32'h0;
        last_instr = 32'h0;
        @(negedge clk);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_count", retired_count, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'd1);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        @(posedge clk); #1;

        step(32'h0000_0020, 1, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0004);
        chk_fetch_cycle();

        chk("fetch_q_empty", fetch_q.size(), 32'd0);
        chk("retire_q_empty", retire_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
